// File: rtl/button_conditioner_if.sv
// Button pins in, conditioned per-channel level/edge/auto-repeat pulses out.
// The auto-repeat pulse is carried as rpt because repeat is a reserved word.
interface button_conditioner_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] btn;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] rpt;

  modport master (output btn, input level, rise, fall, rpt);
  modport slave  (input btn, output level, rise, fall, rpt);
endinterface

// File: rtl/button_conditioner.sv
// Per-channel button conditioner: 2-flop sync, stable-for-N debounce, edge
// pulses and an auto-repeat FSM. Channels are fully independent.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | released, or repeat inactive; waiting for a debounced rise
// ST_HOLD   | held; counting HOLD_CYCLES from the rise to the first repeat
// ST_REPEAT | held; pulsing rpt every REPEAT_CYCLES
module button_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int REPEAT_EN       = 1,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_conditioner_if.slave  bus
);

  localparam int DCW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HMAX    = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HCW     = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam logic INV   = (ACTIVE_LOW != 0);

  localparam logic [DCW-1:0] D_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCW-1:0] H_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [HCW-1:0] R_LAST = HCW'(REPEAT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic           pin;
    logic           sync_1;
    logic           sync_2;
    logic [DCW-1:0] dcnt;
    logic           lvl;
    logic           rise_q;
    logic           fall_q;
    logic           rise_evt;
    logic           fall_evt;

    // Inversion happens before the synchroniser so reset means "not pressed".
    assign pin      = bus.btn[i] ^ INV;
    assign rise_evt = (sync_2 != lvl) && (dcnt == D_LAST) && sync_2;
    assign fall_evt = (sync_2 != lvl) && (dcnt == D_LAST) && !sync_2;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_1 <= 1'b0;
        sync_2 <= 1'b0;
        dcnt   <= '0;
        lvl    <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_1 <= pin;
        sync_2 <= sync_1;
        rise_q <= rise_evt;
        fall_q <= fall_evt;
        if (sync_2 == lvl) begin
          dcnt <= '0;
        end else if (dcnt == D_LAST) begin
          lvl  <= sync_2;
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + DCW'(1);
        end
      end
    end

    assign bus.level[i] = lvl;
    assign bus.rise[i]  = rise_q;
    assign bus.fall[i]  = fall_q;

    if (REPEAT_EN != 0) begin : g_rep
      logic [1:0]     state;
      logic [HCW-1:0] hcnt;
      logic           rpt_q;

      // The FSM moves on the same edge that registers rise/fall, so the
      // cycle carrying rise already sits in ST_HOLD with hcnt = 0.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state <= ST_IDLE;
          hcnt  <= '0;
          rpt_q <= 1'b0;
        end else begin
          rpt_q <= 1'b0;
          if (fall_evt) begin
            state <= ST_IDLE;
            hcnt  <= '0;
          end else begin
            case (state)
              ST_IDLE: begin
                if (rise_evt) begin
                  state <= ST_HOLD;
                  hcnt  <= '0;
                end
              end
              ST_HOLD: begin
                if (hcnt == H_LAST) begin
                  rpt_q <= 1'b1;
                  state <= ST_REPEAT;
                  hcnt  <= '0;
                end else begin
                  hcnt <= hcnt + HCW'(1);
                end
              end
              ST_REPEAT: begin
                if (hcnt == R_LAST) begin
                  rpt_q <= 1'b1;
                  hcnt  <= '0;
                end else begin
                  hcnt <= hcnt + HCW'(1);
                end
              end
              default: begin
                state <= ST_IDLE;
                hcnt  <= '0;
              end
            endcase
          end
        end
      end

      assign bus.rpt[i] = rpt_q;
    end else begin : g_norep
      assign bus.rpt[i] = 1'b0;
    end
  end

endmodule
